// File: rtl/datapath_mc.sv
// -----------------------------------------------------------------------------
// datapath_mc -- multi-cycle RV32I datapath.
//
// A four-state sequencer (FETCH -> EXEC -> [MEM] -> WB) steps one instruction
// at a time. The instruction and data sides use valid/ready-style handshakes,
// so memories of any latency can be attached. Decode is done outside this block
// by the control unit (UC). The UC sees opecode/f3/f7 from the instruction
// register and returns the control inputs below.
//
// Parameters
//   PC_WIDTH  PC / instruction-address width (8..32)
//   RESET_PC  PC loaded on reset (low two bits zero)
//   NREGS     architectural registers (16 or 32); indices are truncated
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   instr, instrValid          fetched word and its valid strobe
//   readData, memValid         load data / data-access completion
//   branch..regWrite           UC control (sampled in EXEC, MEM, WB only)
//   pc, instrReq               instruction address and fetch request
//   ALUResult, writeData       registered data address and store data
//   memReq, memWe              data-access request and write qualifier
//   zero                       combinational ALU zero flag
//   opecode, f3, f7            instruction fields for the UC
//   instrRetired               one-cycle pulse in the write-back cycle
// -----------------------------------------------------------------------------
module datapath_mc #(
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned NREGS    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instrValid,
  input  logic [31:0]         readData,
  input  logic                memValid,
  input  logic                branch,
  input  logic                jump,
  input  logic                jalr,
  input  logic [1:0]          resultSrc,
  input  logic [2:0]          ALUControl,
  input  logic                ALUSrc,
  input  logic [2:0]          inmSrc,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic                regWrite,
  output logic [PC_WIDTH-1:0] pc,
  output logic                instrReq,
  output logic [31:0]         ALUResult,
  output logic [31:0]         writeData,
  output logic                memReq,
  output logic                memWe,
  output logic                zero,
  output logic [6:0]          opecode,
  output logic [2:0]          f3,
  output logic                f7,
  output logic                instrRetired
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [31:0]           ir_q, alu_out_q, a_q, b_q, mdr_q;
  logic                  zero_q;
  logic [31:0]           rf_q [NREGS];

  logic [RIDX_W-1:0]     rs1_idx, rs2_idx, rd_idx;
  logic [31:0]           rs1_val, rs2_val, src_b, imm_ext, alu_res, result;
  logic [PC_WIDTH-1:0]   pc_plus4, pc_target, pc_sel, pc_next;
  logic                  taken;

  // Operand A is captured for trace/debug visibility; the ALU reads the
  // register file directly in EXEC, so nothing downstream consumes it.
  logic unused_a;
  assign unused_a = ^a_q;

  // ---------------------------------------------------------------------------
  // Instruction fields and register-file read (x0 hard-wired to zero)
  // ---------------------------------------------------------------------------
  assign opecode = ir_q[6:0];
  assign f3      = ir_q[14:12];
  assign f7      = ir_q[30];

  assign rs1_idx = ir_q[15 +: RIDX_W];
  assign rs2_idx = ir_q[20 +: RIDX_W];
  assign rd_idx  = ir_q[7  +: RIDX_W];

  assign rs1_val = (rs1_idx == '0) ? 32'd0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? 32'd0 : rf_q[rs2_idx];

  // ---------------------------------------------------------------------------
  // Immediate generation
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    imm_ext = 32'd0;
    case (inmSrc)
      3'b000:  imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
      3'b001:  imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'b010:  imm_ext = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'b011:  imm_ext = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      3'b100:  imm_ext = {ir_q[31:12], 12'd0};
      default: imm_ext = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign src_b = ALUSrc ? imm_ext : rs2_val;

  always_comb begin
    alu_res = 32'd0;
    case (ALUControl)
      3'b000: alu_res = rs1_val + src_b;
      3'b001: alu_res = rs1_val - src_b;
      3'b010: alu_res = rs1_val & src_b;
      3'b011: alu_res = rs1_val | src_b;
      3'b100: alu_res = rs1_val ^ src_b;
      3'b101: alu_res = {31'd0, $signed(rs1_val) < $signed(src_b)};
      3'b110: alu_res = rs1_val >> src_b[4:0];
      3'b111: alu_res = rs1_val << src_b[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  assign zero = (alu_res == 32'd0);

  // ---------------------------------------------------------------------------
  // Next PC and write-back value (used in WB, where IR and ALUOut are stable)
  // ---------------------------------------------------------------------------
  // beq has f3[0] = 0, bne has f3[0] = 1, so IR[12] inverts the zero sense.
  assign taken     = branch & (zero_q ^ ir_q[12]);
  assign pc_plus4  = pc_q + PC_WIDTH'(4);
  assign pc_target = pc_q + imm_ext[PC_WIDTH-1:0];

  always_comb begin
    pc_sel = pc_plus4;
    if (jalr)
      pc_sel = alu_out_q[PC_WIDTH-1:0];
    else if (jump || taken)
      pc_sel = pc_target;
  end

  // Instruction addresses stay word aligned even for odd JALR targets.
  assign pc_next = pc_sel & ~PC_WIDTH'(3);

  always_comb begin
    result = alu_out_q;
    case (resultSrc)
      2'b00: result = alu_out_q;
      2'b01: result = mdr_q;
      2'b10: result = imm_ext;
      2'b11: result = 32'(pc_plus4);
      default: result = alu_out_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state register plus next-state / handshake decode
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    instrReq     = 1'b0;
    memReq       = 1'b0;
    memWe        = 1'b0;
    instrRetired = 1'b0;
    case (state_q)
      S_FETCH: begin
        instrReq = 1'b1;
        if (instrValid) state_d = S_EXEC;
      end
      S_EXEC:  state_d = (memRead || memWrite) ? S_MEM : S_WB;
      S_MEM: begin
        memReq = 1'b1;
        memWe  = memWrite;
        if (memValid) state_d = S_WB;
      end
      S_WB: begin
        instrRetired = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Requests must not leak out while reset is held, whatever state we are in.
    if (!rst_n) begin
      instrReq     = 1'b0;
      memReq       = 1'b0;
      memWe        = 1'b0;
      instrRetired = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= PC_WIDTH'(RESET_PC);
      ir_q      <= 32'd0;
      alu_out_q <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      mdr_q     <= 32'd0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (instrValid) ir_q <= instr;
        S_EXEC: begin
          a_q       <= rs1_val;
          b_q       <= rs2_val;
          alu_out_q <= alu_res;
          zero_q    <= zero;
        end
        S_MEM:   if (memValid) mdr_q <= readData;
        S_WB:    pc_q <= pc_next;
        default: ;
      endcase
    end
  end

  // NOTE: the register file has no reset; its contents survive rst_n, and
  // leaving it out of reset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == S_WB) && regWrite && (rd_idx != '0))
      rf_q[rd_idx] <= result;
  end

  assign pc        = pc_q;
  assign ALUResult = alu_out_q;
  assign writeData = b_q;

endmodule
